// File: rtl/dp_issue_ctrl_pkg.sv
// Shared constants for the data-processing issue controller: op-unit
// indices, APSR bit positions within a {c,z,n} flag triple, counter width.
package dp_issue_ctrl_pkg;

    // Op-unit indices on the en_inst / res_bus / flag_bus buses
    localparam int unsigned OP_AND = 0;
    localparam int unsigned OP_OR  = 1;
    localparam int unsigned OP_EOR = 2;
    localparam int unsigned OP_BIC = 3;
    localparam int unsigned OP_MVN = 4;
    localparam int unsigned OP_ORN = 5;
    localparam int unsigned OP_TST = 6;
    localparam int unsigned OP_TEQ = 7;

    // Bit positions of C/Z/N inside a 3-bit {c,z,n} flag field
    localparam int unsigned APSR_C_BIT = 2;
    localparam int unsigned APSR_Z_BIT = 1;
    localparam int unsigned APSR_N_BIT = 0;

    // Width of the unit-latency down-counter (OP_LAT <= 15)
    localparam int unsigned CNT_W = 4;

    typedef logic [2:0] flags_t;

endpackage

// File: rtl/dp_result_mux.sv
// Selects the 32-bit result and {c,z,n} flags of one op unit from the
// concatenated unit output buses.
module dp_result_mux
    import dp_issue_ctrl_pkg::*;
#(
    parameter int unsigned NUM_OPS = 8,
    parameter int unsigned OP_W    = 3
) (
    input  logic [OP_W-1:0]       i_sel,
    input  logic [32*NUM_OPS-1:0] i_res_bus,
    input  logic [3*NUM_OPS-1:0]  i_flag_bus,
    output logic [31:0]           o_res,
    output flags_t                o_flags
);

    // Pick slice [i_sel]; an out-of-range select yields zero
    always_comb begin
        o_res   = '0;
        o_flags = '0;
        for (int unsigned i = 0; i < NUM_OPS; i++) begin
            if (i_sel == OP_W'(i)) begin
                o_res   = i_res_bus[32*i +: 32];
                o_flags = i_flag_bus[3*i +: 3];
            end
        end
    end

endmodule

// File: rtl/dp_issue_ctrl.sv
// Single-issue sequencer for the data-processing op units: accepts a decoded
// instruction, pulses the selected unit, waits its latency, captures the
// result and flags, and retires them through a valid/ready writeback port
// while owning the APSR C/Z/N bits fed back to every unit.
module dp_issue_ctrl
    import dp_issue_ctrl_pkg::*;
#(
    parameter int unsigned NUM_OPS = 8,
    parameter int unsigned OP_W    = 3,
    parameter int unsigned OP_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [OP_W-1:0]       dec_op,
    input  logic                  dec_s,
    input  logic [3:0]            dec_rd,
    output logic [NUM_OPS-1:0]    en_inst,
    input  logic [32*NUM_OPS-1:0] res_bus,
    input  logic [3*NUM_OPS-1:0]  flag_bus,
    output logic                  apsr_c,
    output logic                  apsr_z,
    output logic                  apsr_n,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [3:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  busy,
    output logic                  op_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [OP_W-1:0]    r_op;
    logic               r_s;
    logic [3:0]         r_rd;
    logic [CNT_W-1:0]   r_cnt;
    flags_t             r_flags;
    flags_t             r_apsr;
    logic [NUM_OPS-1:0] r_en_inst;
    logic               r_op_err;
    logic               r_wb_valid;
    logic [3:0]         r_wb_rd;
    logic [31:0]        r_wb_data;
    logic               r_busy;
    logic               r_dec_ready;
    logic [NUM_OPS-1:0] w_en_nxt;
    logic               w_err_nxt;
    logic               w_op_legal;
    logic [31:0]        w_mux_res;
    flags_t             w_mux_flags;

    assign w_op_legal = (32'(dec_op) < NUM_OPS);

    dp_result_mux #(
        .NUM_OPS (NUM_OPS),
        .OP_W    (OP_W)
    ) u_result_mux (
        .i_sel      (r_op),
        .i_res_bus  (res_bus),
        .i_flag_bus (flag_bus),
        .o_res      (w_mux_res),
        .o_flags    (w_mux_flags)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next values of the pulse outputs (en_inst, op_err)
    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = '0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dec_valid) begin
                    if (w_op_legal) begin
                        w_state_nxt = S_ISSUE;
                        for (int unsigned i = 0; i < NUM_OPS; i++) begin
                            w_en_nxt[i] = (dec_op == OP_W'(i));
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_state_nxt = S_WB;
            S_WB:    if (wb_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs, latched instruction fields, latency counter, APSR.
    // Status outputs are registered from the next state so that each one is
    // valid in the same cycle as the state it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_inst   <= '0;
            r_op_err    <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_busy      <= 1'b0;
            r_dec_ready <= 1'b1;
            r_apsr      <= '0;
            r_flags     <= '0;
            r_op        <= '0;
            r_s         <= 1'b0;
            r_rd        <= '0;
            r_cnt       <= '0;
        end else begin
            r_en_inst   <= w_en_nxt;
            r_op_err    <= w_err_nxt;
            r_wb_valid  <= (w_state_nxt == S_WB);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_dec_ready <= (w_state_nxt == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (dec_valid) begin
                        r_op <= dec_op;
                        r_s  <= dec_s;
                        r_rd <= dec_rd;
                    end
                end
                S_ISSUE: r_cnt <= CNT_W'(OP_LAT - 1);
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_wb_data <= w_mux_res;
                        r_wb_rd   <= r_rd;
                        r_flags   <= w_mux_flags;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WB: begin
                    if (wb_ready && r_s) begin
                        r_apsr <= r_flags;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dec_ready = r_dec_ready;
    assign en_inst   = r_en_inst;
    assign apsr_c    = r_apsr[APSR_C_BIT];
    assign apsr_z    = r_apsr[APSR_Z_BIT];
    assign apsr_n    = r_apsr[APSR_N_BIT];
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign busy      = r_busy;
    assign op_err    = r_op_err;

endmodule

// File: tb/tb_dp_issue_ctrl.sv
// Bench for dp_issue_ctrl: two instances (8 units / latency 1 and
// 6 units / latency 4) driven with random transactions against a
// cycle-level transaction model of the issue/wait/writeback protocol.
module tb_dp_issue_ctrl;
    import dp_issue_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Per-instance inputs: index 0 = instance A, 1 = instance B
    logic       dec_valid [2];
    logic [2:0] dec_op    [2];
    logic       dec_s     [2];
    logic [3:0] dec_rd    [2];
    logic       wb_ready  [2];
    logic [31:0] unit_res [2][8];
    logic [2:0]  unit_flg [2][8];

    logic [255:0] res_a;
    logic [23:0]  flg_a;
    logic [191:0] res_b;
    logic [17:0]  flg_b;

    logic        rdy_a, busy_a, wbv_a, err_a, c_a, z_a, n_a;
    logic [7:0]  en_a;
    logic [3:0]  rd_a;
    logic [31:0] data_a;
    logic        rdy_b, busy_b, wbv_b, err_b, c_b, z_b, n_b;
    logic [5:0]  en_b;
    logic [3:0]  rd_b;
    logic [31:0] data_b;

    int checks   = 0;
    int failures = 0;
    logic [2:0] m_apsr [2];

    always_comb begin
        res_a = '0; flg_a = '0; res_b = '0; flg_b = '0;
        for (int i = 0; i < 8; i++) begin
            res_a[32*i +: 32] = unit_res[0][i];
            flg_a[3*i +: 3]   = unit_flg[0][i];
        end
        for (int i = 0; i < 6; i++) begin
            res_b[32*i +: 32] = unit_res[1][i];
            flg_b[3*i +: 3]   = unit_flg[1][i];
        end
    end

    dp_issue_ctrl #(.NUM_OPS(8), .OP_W(3), .OP_LAT(1)) u_a (
        .clk(clk), .rst(rst), .dec_valid(dec_valid[0]), .dec_ready(rdy_a),
        .dec_op(dec_op[0]), .dec_s(dec_s[0]), .dec_rd(dec_rd[0]), .en_inst(en_a),
        .res_bus(res_a), .flag_bus(flg_a), .apsr_c(c_a), .apsr_z(z_a), .apsr_n(n_a),
        .wb_valid(wbv_a), .wb_ready(wb_ready[0]), .wb_rd(rd_a), .wb_data(data_a),
        .busy(busy_a), .op_err(err_a)
    );

    dp_issue_ctrl #(.NUM_OPS(6), .OP_W(3), .OP_LAT(4)) u_b (
        .clk(clk), .rst(rst), .dec_valid(dec_valid[1]), .dec_ready(rdy_b),
        .dec_op(dec_op[1]), .dec_s(dec_s[1]), .dec_rd(dec_rd[1]), .en_inst(en_b),
        .res_bus(res_b), .flag_bus(flg_b), .apsr_c(c_b), .apsr_z(z_b), .apsr_n(n_b),
        .wb_valid(wbv_b), .wb_ready(wb_ready[1]), .wb_rd(rd_b), .wb_data(data_b),
        .busy(busy_b), .op_err(err_b)
    );

    // Control snapshot {dec_ready, busy, wb_valid, op_err, c, z, n, en_inst[7:0]}
    function automatic logic [14:0] ctl(input int idx);
        if (idx == 0) return {rdy_a, busy_a, wbv_a, err_a, c_a, z_a, n_a, en_a};
        return {rdy_b, busy_b, wbv_b, err_b, c_b, z_b, n_b, 2'b00, en_b};
    endfunction

    function automatic logic [35:0] wbo(input int idx);
        if (idx == 0) return {rd_a, data_a};
        return {rd_b, data_b};
    endfunction

    function automatic logic [14:0] mk(input logic rdy, input logic bsy, input logic wbv,
                                       input logic err, input logic [2:0] apsr, input logic [7:0] en);
        return {rdy, bsy, wbv, err, apsr, en};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_units(input int idx);
        for (int i = 0; i < 8; i++) begin
            unit_res[idx][i] = $urandom;
            unit_flg[idx][i] = 3'($urandom);
        end
    endtask

    // One legal instruction through issue, unit latency, stalled writeback, retire.
    // Unit outputs are only meaningful in the final wait cycle; garbage elsewhere.
    task automatic do_txn(input int idx, input logic [2:0] op, input logic s, input logic [3:0] rd,
                          input int stall, input logic [31:0] vres, input logic [2:0] vflg);
        int lat;
        logic [7:0] exp_en;
        logic [14:0] got, exp;
        lat = (idx == 0) ? 1 : 4;
        exp_en = 8'd1 << op;
        got = ctl(idx); exp = mk(1'b1, 1'b0, 1'b0, 1'b0, m_apsr[idx], 8'h00);
        checks++; if (got !== exp) begin failures++; $display("FAIL txn_idle idx=%0d got=%h exp=%h", idx, got, exp); end
        dec_valid[idx] = 1'b1; dec_op[idx] = op; dec_s[idx] = s; dec_rd[idx] = rd;
        wb_ready[idx] = 1'($urandom);
        scramble_units(idx);
        tick();
        got = ctl(idx); exp = mk(1'b0, 1'b1, 1'b0, 1'b0, m_apsr[idx], exp_en);
        checks++; if (got !== exp) begin failures++; $display("FAIL txn_issue idx=%0d op=%0d got=%h exp=%h", idx, op, got, exp); end
        // decoder keeps a further request pending while the controller is busy
        dec_op[idx] = 3'($urandom); dec_s[idx] = 1'($urandom); dec_rd[idx] = 4'($urandom);
        for (int k = 1; k <= lat; k++) begin
            wb_ready[idx] = 1'($urandom);
            tick();
            scramble_units(idx);
            if (k == lat) begin unit_res[idx][op] = vres; unit_flg[idx][op] = vflg; end
            got = ctl(idx); exp = mk(1'b0, 1'b1, 1'b0, 1'b0, m_apsr[idx], 8'h00);
            checks++; if (got !== exp) begin failures++; $display("FAIL txn_wait idx=%0d k=%0d got=%h exp=%h", idx, k, got, exp); end
        end
        wb_ready[idx] = 1'b0;
        tick();
        scramble_units(idx);
        for (int j = 0; j <= stall; j++) begin
            if (j > 0) tick();
            wb_ready[idx] = (j == stall);
            if (j == stall) dec_valid[idx] = 1'b0;
            got = ctl(idx); exp = mk(1'b0, 1'b1, 1'b1, 1'b0, m_apsr[idx], 8'h00);
            checks++; if (got !== exp) begin failures++; $display("FAIL txn_wb_ctl idx=%0d cyc=%0d got=%h exp=%h", idx, j, got, exp); end
            checks++; if (wbo(idx) !== {rd, vres}) begin failures++; $display("FAIL txn_wb_data idx=%0d cyc=%0d got=%h exp=%h", idx, j, wbo(idx), {rd, vres}); end
        end
        tick();
        wb_ready[idx] = 1'($urandom);
        if (s) m_apsr[idx] = vflg;
        got = ctl(idx); exp = mk(1'b1, 1'b0, 1'b0, 1'b0, m_apsr[idx], 8'h00);
        checks++; if (got !== exp) begin failures++; $display("FAIL txn_retire idx=%0d s=%0d got=%h exp=%h", idx, s, got, exp); end
        wb_ready[idx] = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            dec_valid[i] = 1'b1; dec_op[i] = 3'(OP_OR); dec_s[i] = 1'b1; dec_rd[i] = 4'd5;
            wb_ready[i] = 1'b1; scramble_units(i); m_apsr[i] = 3'b000;
        end
        rst = 1'b1;
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            checks++; if (ctl(i) !== mk(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00)) begin failures++; $display("FAIL reset_ctl idx=%0d got=%h exp=%h", i, ctl(i), mk(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00)); end
            checks++; if (wbo(i) !== 36'h0) begin failures++; $display("FAIL reset_wb idx=%0d got=%h exp=0", i, wbo(i)); end
            dec_valid[i] = 1'b0; wb_ready[i] = 1'b0;
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++; if (ctl(i) !== mk(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00)) begin failures++; $display("FAIL reset_release idx=%0d got=%h", i, ctl(i)); end
        end
    endtask

    task automatic test_or_s1();
        do_txn(0, 3'(OP_OR), 1'b1, 4'd3, 0, 32'h0000_0000, 3'b010);
        checks++; if ({c_a, z_a, n_a} !== 3'b010) begin failures++; $display("FAIL or_s1_apsr got=%b exp=010", {c_a, z_a, n_a}); end
    endtask

    task automatic test_s0();
        do_txn(0, 3'(OP_EOR), 1'b0, 4'd9, 0, 32'hDEAD_BEEF, 3'b111);
        do_txn(1, 3'(OP_AND), 1'b0, 4'd1, 1, 32'h1234_5678, 3'b111);
    endtask

    task automatic test_backpressure();
        do_txn(0, 3'(OP_BIC), 1'b1, 4'd12, 5, $urandom, 3'b101);
        do_txn(1, 3'(OP_ORN), 1'b1, 4'd7, 5, $urandom, 3'b011);
    endtask

    task automatic test_illegal();
        for (int v = 6; v <= 7; v++) begin
            dec_valid[1] = 1'b1; dec_op[1] = 3'(v); dec_s[1] = 1'b1; dec_rd[1] = 4'($urandom);
            tick();
            dec_valid[1] = 1'b0;
            checks++; if (ctl(1) !== mk(1'b1, 1'b0, 1'b0, 1'b1, m_apsr[1], 8'h00)) begin failures++; $display("FAIL illegal_pulse op=%0d got=%h exp=%h", v, ctl(1), mk(1'b1, 1'b0, 1'b0, 1'b1, m_apsr[1], 8'h00)); end
            for (int k = 0; k < 3; k++) begin
                tick();
                checks++; if (ctl(1) !== mk(1'b1, 1'b0, 1'b0, 1'b0, m_apsr[1], 8'h00)) begin failures++; $display("FAIL illegal_after op=%0d k=%0d got=%h", v, k, ctl(1)); end
            end
        end
    endtask

    task automatic test_random();
        int idx, nops;
        for (int n = 0; n < 40; n++) begin
            idx = int'($urandom_range(0, 1));
            nops = (idx == 0) ? 8 : 6;
            do_txn(idx, 3'($urandom_range(0, nops - 1)), 1'($urandom), 4'($urandom),
                   int'($urandom_range(0, 3)), $urandom, 3'($urandom));
        end
    endtask

    task automatic test_reset_wait();
        do_txn(1, 3'(OP_MVN), 1'b1, 4'd2, 0, $urandom, 3'b101);
        dec_valid[1] = 1'b1; dec_op[1] = 3'(OP_OR); dec_s[1] = 1'b1; dec_rd[1] = 4'd4;
        tick();
        dec_valid[1] = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_apsr[0] = 3'b000; m_apsr[1] = 3'b000;
        for (int i = 0; i < 2; i++) begin
            checks++; if (ctl(i) !== mk(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00)) begin failures++; $display("FAIL rst_wait_ctl idx=%0d got=%h", i, ctl(i)); end
        end
        for (int k = 0; k < 8; k++) begin
            scramble_units(1);
            wb_ready[1] = 1'($urandom);
            tick();
            checks++; if (ctl(1) !== mk(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00)) begin failures++; $display("FAIL rst_wait_idle k=%0d got=%h", k, ctl(1)); end
        end
        wb_ready[1] = 1'b0;
        do_txn(1, 3'(OP_EOR), 1'b1, 4'd15, 0, $urandom, 3'b110);
    endtask

    initial begin
        test_reset();
        test_or_s1();
        test_s0();
        test_backpressure();
        test_illegal();
        test_random();
        test_reset_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
